// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue scheduler: execution unit IDs and CDB slot record.
package issue_scheduler_pkg;

    typedef enum logic [1:0] {
        UNIT_INT   = 2'd0,
        UNIT_LD_ST = 2'd1,
        UNIT_MULT  = 2'd2,
        UNIT_DIV   = 2'd3
    } issue_unit_e;

    typedef struct packed {
        logic        valid;
        issue_unit_e unit;
    } cdb_slot_t;

    // Depth of the reservation window: the longest unit latency.
    function automatic int unsigned lat_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cdb_reservation_sr.sv
// CDB reservation shift register: slot[k] names the CDB owner k cycles ahead.
module cdb_reservation_sr
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned D  = 8,
    parameter int unsigned IW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          claim_valid,
    input  logic [IW-1:0] claim_idx,
    input  issue_unit_e   claim_unit,
    output logic [D:0]    slot_valid,
    output cdb_slot_t     head
);

    cdb_slot_t slot_q [D+1];

    // Advance the window one cycle; a claim lands in the shifted position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= D; k++) slot_q[k] <= '0;
        end else if (flush) begin
            for (int unsigned k = 0; k <= D; k++) slot_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < D; k++) begin
                if (claim_valid && (claim_idx == IW'(k)))
                    slot_q[k] <= '{valid: 1'b1, unit: claim_unit};
                else
                    slot_q[k] <= slot_q[k+1];
            end
            slot_q[D] <= '0;
        end
    end

    // Expose per-slot occupancy for eligibility checks.
    always_comb begin
        slot_valid = '0;
        for (int unsigned k = 0; k <= D; k++) slot_valid[k] = slot_q[k].valid;
    end

    assign head = slot_q[0];

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue scheduler arbitrating four execution queues onto one CDB.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_int_ready,
    input  logic       i_ld_st_ready,
    input  logic       i_mult_ready,
    input  logic       i_div_ready,
    input  logic       i_flush,
    output logic       o_int_issue,
    output logic       o_ld_st_issue,
    output logic       o_mult_issue,
    output logic       o_div_issue,
    output logic       o_cdb_owner_valid,
    output logic [1:0] o_cdb_owner,
    output logic       o_div_busy
);

    localparam int unsigned D  = lat_max(MULT_LAT, DIV_LAT);
    localparam int unsigned IW = $clog2(D + 1);
    localparam int unsigned CW = $clog2(DIV_LAT);

    logic [D:0]    slot_valid;
    cdb_slot_t     head;
    logic          claim_valid;
    logic [IW-1:0] claim_idx;
    issue_unit_e   claim_unit;
    logic [CW-1:0] div_cnt;
    logic          rr;
    logic          int_elig, ld_st_elig, mult_elig, div_elig;
    logic          unused_slots;

    cdb_reservation_sr #(.D(D), .IW(IW)) u_sr (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .flush       (i_flush),
        .claim_valid (claim_valid),
        .claim_idx   (claim_idx),
        .claim_unit  (claim_unit),
        .slot_valid  (slot_valid),
        .head        (head)
    );

    // Only the slots at each unit's latency are examined; the rest are tracked for shifting.
    assign unused_slots = ^slot_valid;

    // A unit may issue only if its CDB slot at completion time is free.
    always_comb begin
        int_elig   = i_int_ready   && !slot_valid[1];
        ld_st_elig = i_ld_st_ready && !slot_valid[1];
        mult_elig  = i_mult_ready  && !slot_valid[MULT_LAT];
        div_elig   = i_div_ready   && !slot_valid[DIV_LAT] && (div_cnt == '0);
    end

    // Fixed priority div > mult > int/ld_st (round-robin); claim slot L-1 post-shift.
    always_comb begin
        o_int_issue   = 1'b0;
        o_ld_st_issue = 1'b0;
        o_mult_issue  = 1'b0;
        o_div_issue   = 1'b0;
        claim_valid   = 1'b0;
        claim_idx     = '0;
        claim_unit    = UNIT_INT;
        if (i_rst_n && !i_flush) begin
            if (div_elig) begin
                o_div_issue = 1'b1;
                claim_valid = 1'b1;
                claim_idx   = IW'(DIV_LAT - 1);
                claim_unit  = UNIT_DIV;
            end else if (mult_elig) begin
                o_mult_issue = 1'b1;
                claim_valid  = 1'b1;
                claim_idx    = IW'(MULT_LAT - 1);
                claim_unit   = UNIT_MULT;
            end else if (ld_st_elig && (rr || !int_elig)) begin
                o_ld_st_issue = 1'b1;
                claim_valid   = 1'b1;
                claim_unit    = UNIT_LD_ST;
            end else if (int_elig) begin
                o_int_issue = 1'b1;
                claim_valid = 1'b1;
                claim_unit  = UNIT_INT;
            end
        end
    end

    // Divider occupancy counter and int/ld_st round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            rr      <= 1'b0;
        end else if (i_flush) begin
            div_cnt <= '0;
            rr      <= 1'b0;
        end else begin
            if (o_div_issue)
                div_cnt <= CW'(DIV_LAT - 1);
            else if (div_cnt != '0)
                div_cnt <= div_cnt - CW'(1);
            if (o_int_issue)
                rr <= 1'b1;
            else if (o_ld_st_issue)
                rr <= 1'b0;
        end
    end

    assign o_cdb_owner_valid = head.valid;
    assign o_cdb_owner       = head.unit;
    assign o_div_busy        = (div_cnt != '0);

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed self-checking bench for issue_scheduler with MULT_LAT=4, DIV_LAT=8.
module tb_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       int_rdy, ls_rdy, mult_rdy, div_rdy, flush;
    logic       int_iss, ls_iss, mult_iss, div_iss;
    logic       own_v;
    logic [1:0] own;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    issue_scheduler #(.MULT_LAT(4), .DIV_LAT(8)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_int_ready       (int_rdy),
        .i_ld_st_ready     (ls_rdy),
        .i_mult_ready      (mult_rdy),
        .i_div_ready       (div_rdy),
        .i_flush           (flush),
        .o_int_issue       (int_iss),
        .o_ld_st_issue     (ls_iss),
        .o_mult_issue      (mult_iss),
        .o_div_issue       (div_iss),
        .o_cdb_owner_valid (own_v),
        .o_cdb_owner       (own),
        .o_div_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rdy(input logic [3:0] r); // {div, mult, ld_st, int}
        {div_rdy, mult_rdy, ls_rdy, int_rdy} = r;
    endtask

    // One cycle: sample mid-cycle, then advance to just after the next rising edge.
    // g = {div, mult, ld_st, int}
    task automatic cyc(input string tag, input int t, input logic [3:0] g,
                       input logic v, input logic [1:0] o, input logic b);
        @(negedge clk);
        check($sformatf("%s[%0d] grant", tag, t), {28'd0, div_iss, mult_iss, ls_iss, int_iss}, {28'd0, g});
        check($sformatf("%s[%0d] owner_valid", tag, t), {31'd0, own_v}, {31'd0, v});
        if (v) check($sformatf("%s[%0d] owner", tag, t), {30'd0, own}, {30'd0, o});
        check($sformatf("%s[%0d] div_busy", tag, t), {31'd0, busy}, {31'd0, b});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] g;
        logic       v;
        logic [1:0] o;

        rst_n = 1'b0;
        flush = 1'b0;
        set_rdy(4'b1111);

        // Reset: grants held off even with every queue ready.
        @(negedge clk);
        check("reset grant", {28'd0, div_iss, mult_iss, ls_iss, int_iss}, 32'd0);
        check("reset owner_valid", {31'd0, own_v}, 32'd0);
        check("reset owner", {30'd0, own}, 32'd0);
        check("reset div_busy", {31'd0, busy}, 32'd0);
        set_rdy(4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle
        for (int t = 0; t < 20; t++) cyc("idle", t, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Int/ld_st round-robin, int first; owner follows one cycle later
        set_rdy(4'b0011);
        for (int t = 0; t < 6; t++) begin
            g = (t % 2 == 0) ? 4'b0001 : 4'b0010;
            o = (t % 2 == 1) ? 2'd0 : 2'd1;
            cyc("rr", t, g, t > 0, o, 1'b0);
        end
        set_rdy(4'b0000);
        cyc("rr", 6, 4'b0000, 1'b1, 2'd1, 1'b0);
        cyc("rr", 7, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Mult at 0 holds slot[1] at cycle 3, so int waits until cycle 4
        set_rdy(4'b0100);
        cyc("coll", 0, 4'b0100, 1'b0, 2'd0, 1'b0);
        set_rdy(4'b0000);
        cyc("coll", 1, 4'b0000, 1'b0, 2'd0, 1'b0);
        cyc("coll", 2, 4'b0000, 1'b0, 2'd0, 1'b0);
        set_rdy(4'b0001);
        cyc("coll", 3, 4'b0000, 1'b0, 2'd0, 1'b0);
        cyc("coll", 4, 4'b0001, 1'b1, 2'd2, 1'b0);
        set_rdy(4'b0000);
        cyc("coll", 5, 4'b0000, 1'b1, 2'd0, 1'b0);
        cyc("coll", 6, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Divider back-to-back with int filling gaps (int blocked when div owns next slot)
        for (int t = 0; t <= 24; t++) begin
            set_rdy(t <= 16 ? 4'b1001 : 4'b0000);
            if (t == 0 || t == 8 || t == 16) g = 4'b1000;
            else if (t < 16 && (t % 8) >= 1 && (t % 8) <= 6) g = 4'b0001;
            else g = 4'b0000;
            if (t == 8 || t == 16 || t == 24) begin
                v = 1'b1; o = 2'd3;
            end else if ((t >= 2 && t <= 7) || (t >= 10 && t <= 15)) begin
                v = 1'b1; o = 2'd0;
            end else begin
                v = 1'b0; o = 2'd0;
            end
            cyc("div", t, g, v, o, (t % 8) != 0);
        end

        // Flush after div and mult issue; int result due in flush cycle still shown
        set_rdy(4'b1000);
        cyc("flush", 0, 4'b1000, 1'b0, 2'd0, 1'b0);
        set_rdy(4'b0100);
        cyc("flush", 1, 4'b0100, 1'b0, 2'd0, 1'b1);
        set_rdy(4'b0001);
        cyc("flush", 2, 4'b0001, 1'b0, 2'd0, 1'b1);
        set_rdy(4'b1111);
        flush = 1'b1;
        cyc("flush", 3, 4'b0000, 1'b1, 2'd0, 1'b1);
        flush = 1'b0;
        set_rdy(4'b1000);
        cyc("flush", 4, 4'b1000, 1'b0, 2'd0, 1'b0);
        set_rdy(4'b0000);
        for (int t = 5; t <= 12; t++)
            cyc("flush", t, 4'b0000, t == 12, 2'd3, t != 12);

        // Simultaneous ready: div, then mult, then int, then ld_st
        set_rdy(4'b1111);
        cyc("simul", 0, 4'b1000, 1'b0, 2'd0, 1'b0);
        cyc("simul", 1, 4'b0100, 1'b0, 2'd0, 1'b1);
        set_rdy(4'b1011);
        cyc("simul", 2, 4'b0001, 1'b0, 2'd0, 1'b1);
        cyc("simul", 3, 4'b0010, 1'b1, 2'd0, 1'b1);
        set_rdy(4'b0000);
        cyc("simul", 4, 4'b0000, 1'b1, 2'd1, 1'b1);
        cyc("simul", 5, 4'b0000, 1'b1, 2'd2, 1'b1);
        cyc("simul", 6, 4'b0000, 1'b0, 2'd0, 1'b1);
        cyc("simul", 7, 4'b0000, 1'b0, 2'd0, 1'b1);
        cyc("simul", 8, 4'b0000, 1'b1, 2'd3, 1'b0);

        // Asynchronous reset mid-operation discards the pending mult and div
        set_rdy(4'b1100);
        cyc("rstmid", 0, 4'b1000, 1'b0, 2'd0, 1'b0);
        cyc("rstmid", 1, 4'b0100, 1'b0, 2'd0, 1'b1);
        set_rdy(4'b1111);
        #2;
        rst_n = 1'b0;
        cyc("rstmid", 2, 4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        set_rdy(4'b0000);
        for (int t = 3; t <= 10; t++) cyc("rstmid", t, 4'b0000, 1'b0, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

- Picks at most one instruction per cycle from the four execution queues (integer, load/store, multiply, divide) and issues it.
- Its one-hot issue pulses drive the queues' `rd_en`.
- Keeps a per-cycle reservation of the single Common Data Bus (CDB) so no two units ever complete in the same cycle.
- Sits between the dispatch-side execution queues and the execution units, and publishes which unit owns the CDB each cycle.

## Interface
Parameters:
- `MULT_LAT`, default 4: multiplier latency (pipelined, ≥2); result on CDB MULT_LAT cycles after issue.
- `DIV_LAT`, default 8: divider latency (non-pipelined, ≥2).
- Integer and load/store latency is fixed at 1.

Ports:
- `i_clk`  in  1: clock, the only clock.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_int_ready`, `i_ld_st_ready`, `i_mult_ready`, `i_div_ready`  in  1 each: queue head valid with operands ready.
- `i_flush`  in  1: synchronous flush (branch mispredict).
- `o_int_issue`, `o_ld_st_issue`, `o_mult_issue`, `o_div_issue`  out  1 each: issue grant, one-hot or zero, combinational.
- `o_cdb_owner_valid`  out  1: a unit drives the CDB this cycle.
- `o_cdb_owner`  out  2: owning unit ID for this cycle.
- `o_div_busy`  out  1: divider occupied.

## Operation
- **Reservation register.** Slots `slot[0..D]`, with D = max(MULT_LAT, DIV_LAT). Each slot is {valid, unit[1:0]}. `slot[k]` is the CDB owner k cycles from now.
- **Shift.** Every clock, `slot[k] <= slot[k+1]` and `slot[D]` is cleared.
- **Eligibility.**
  - A unit with latency L is eligible when its ready is high and `slot[L].valid == 0`.
  - Divide additionally requires `div_cnt == 0`.
- **Grant priority.**
  - Order: div, then mult, then int/ld_st.
  - Int and ld_st are round-robin via `rr` (0 = int preferred).
  - Exactly one grant is issued when any unit is eligible.
- **On grant of a unit with latency L.** The shifted value written is `slot[L-1] <= {1, unit}`. This equals old `slot[L]` being claimed, so the result appears on `o_cdb_owner` exactly L cycles after the issue cycle.
- **Round-robin update.** An int grant sets `rr = 1`; a ld_st grant sets `rr = 0`; other grants leave `rr` unchanged.
- **Divider counter.** A div grant loads `div_cnt <= DIV_LAT-1`; otherwise `div_cnt` decrements when nonzero. `o_div_busy = (div_cnt != 0)`.
- **Unit IDs.** INT=0, LD_ST=1, MULT=2, DIV=3.
- **Starvation.** A continuous multiply stream may starve int/ld_st. This is accepted; dispatch throttling is handled elsewhere.

## Timing
- **Reset.** All slots invalid, `div_cnt = 0`, `rr = 0`.
  - `o_cdb_owner_valid = 0`, `o_cdb_owner = 0`, `o_div_busy = 0`.
  - All issue outputs are 0 while `i_rst_n` is low.
- **Issue latency.** Grants are combinational from the ready inputs and registered state, in the same cycle. The queue pops on that clock edge.
- **CDB ownership.** `o_cdb_owner*` are registered (`slot[0]`). They are valid in cycle t+L for an issue in cycle t.
- **Divider throughput.** A div issued at t makes div ineligible for t+1..t+DIV_LAT-1; it is eligible again at t+DIV_LAT.
- **Flush, in the flush cycle.**
  - All grants are forced to 0.
  - `slot[0]` is still presented, because that result is already on the CDB.
- **Flush, on the next edge.** All slots are cleared, `div_cnt = 0`, `rr = 0`.
- **Collision.** If a mult issued earlier already holds `slot[1]`, int and ld_st are blocked that cycle even with ready high.
- **Equal latencies.** If MULT_LAT == DIV_LAT, both target the same slot; div wins and mult waits.
- **Reset mid-operation.** Asynchronous clear of all state; in-flight reservations are discarded.

## Structure
- Add to the shared `utils.sv` package:
  - enum `issue_unit_e` (INT, LD_ST, MULT, DIV; 2 bits);
  - struct `cdb_slot_t` {valid, `issue_unit_e` unit}.
- Sub-module `cdb_reservation_sr`, parameter D:
  - holds the shift register;
  - exposes per-slot valid bits;
  - takes a claim port (index, unit);
  - presents `slot[0]`.
- Arbitration, the divider counter and `rr` stay in `issue_scheduler`.

## Test plan
- **Reset and idle.** Release reset, all ready low → no grants; `o_cdb_owner_valid = 0` and `o_div_busy = 0` for 20 cycles.
- **Int/ld_st round-robin.** Int and ld_st ready continuously → grants alternate int, ld_st, int, … starting with int. `o_cdb_owner` follows 1 cycle later as 0, 1, 0, …
- **Multiply then integer collision** (MULT_LAT=4). Mult issued at cycle 0; int ready from cycle 3 → int is blocked at cycle 3 (slot[1] held) and issues at cycle 4. Owner is 2 at cycle 4 and 0 at cycle 5.
- **Divider back-to-back** (DIV_LAT=8). `i_div_ready` held high → div issues at cycles 0, 8, 16; `o_div_busy` is high over cycles 1–7. Owner 3 appears at cycles 8, 16 and 24; mult and int fill the gaps.
- **Simultaneous ready.** All four ready in one cycle → `o_div_issue` only; the next cycle mult issues, then int.
- **Flush.** Flush one cycle after a mult and a div issue → no grants in the flush cycle. From the next cycle, slots are empty, `o_div_busy = 0`, and a new div is accepted immediately.
